// File: rtl/alu_result_queue_if.sv
// rtl/alu_result_queue_if.sv - result stream between the ALU result queue and its consumer
interface alu_result_queue_if #(
    parameter int OUT_WIDTH = 10
);
    logic [OUT_WIDTH-1:0] Res_Data;
    logic [1:0]           Res_Src;
    logic                 Res_Valid;
    logic                 Res_Ready;

    modport master (
        output Res_Data,
        output Res_Src,
        output Res_Valid,
        input  Res_Ready
    );

    modport slave (
        input  Res_Data,
        input  Res_Src,
        input  Res_Valid,
        output Res_Ready
    );
endinterface

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - tags ALU unit results by source and buffers them in a FWFT queue
module alu_result_queue #(
    parameter int ARITH_WIDTH = 10,
    parameter int LOGIC_WIDTH = 5,
    parameter int CMP_WIDTH   = 3,
    parameter int SHIFT_WIDTH = 5,
    parameter int OUT_WIDTH   = 10,
    parameter int DEPTH       = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [ARITH_WIDTH-1:0]     Arith_OUT,
    input  logic                       Arith_Flag,
    input  logic [LOGIC_WIDTH-1:0]     Logic_OUT,
    input  logic                       Logic_Flag,
    input  logic [CMP_WIDTH-1:0]       CMP_OUT,
    input  logic                       CMP_Flag,
    input  logic [SHIFT_WIDTH-1:0]     SHIFT_OUT,
    input  logic                       SHIFT_Flag,
    input  logic                       CLR,
    alu_result_queue_if.master         res,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Overflow,
    output logic                       Collision
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = OUT_WIDTH + 2;

    localparam logic [1:0] SRC_ARITH = 2'b00;
    localparam logic [1:0] SRC_LOGIC = 2'b01;
    localparam logic [1:0] SRC_CMP   = 2'b10;
    localparam logic [1:0] SRC_SHIFT = 2'b11;

    // Each entry holds {source tag, zero-extended data}
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          collision_q;

    logic [OUT_WIDTH-1:0] sel_data;
    logic [1:0]           sel_src;
    logic                 any_flag;
    logic                 multi_flag;
    logic [2:0]           flag_sum;
    logic                 full_w;
    logic                 empty_w;
    logic                 pop;
    logic                 push;
    logic                 drop;

    always_comb begin
        sel_data = '0;
        sel_src  = SRC_ARITH;
        if (Arith_Flag) begin
            sel_data = OUT_WIDTH'(Arith_OUT);
            sel_src  = SRC_ARITH;
        end else if (Logic_Flag) begin
            sel_data = OUT_WIDTH'(Logic_OUT);
            sel_src  = SRC_LOGIC;
        end else if (CMP_Flag) begin
            sel_data = OUT_WIDTH'(CMP_OUT);
            sel_src  = SRC_CMP;
        end else if (SHIFT_Flag) begin
            sel_data = OUT_WIDTH'(SHIFT_OUT);
            sel_src  = SRC_SHIFT;
        end
    end

    assign flag_sum   = {2'b00, Arith_Flag} + {2'b00, Logic_Flag}
                      + {2'b00, CMP_Flag}   + {2'b00, SHIFT_Flag};
    assign any_flag   = (flag_sum != 3'd0);
    assign multi_flag = (flag_sum > 3'd1);

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A full queue still accepts when the head leaves on the same edge
    assign pop  = ~empty_w & res.Res_Ready;
    assign push = any_flag & (~full_w | pop);
    assign drop = any_flag & full_w & ~pop;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!CLR && push) begin
            mem[wr_ptr] <= {sel_src, sel_data};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else if (CLR) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (multi_flag) begin
                collision_q <= 1'b1;
            end
        end
    end

    assign res.Res_Data  = mem[rd_ptr][OUT_WIDTH-1:0];
    assign res.Res_Src   = mem[rd_ptr][EW-1 -: 2];
    assign res.Res_Valid = ~empty_w;

    assign Count     = count_q;
    assign Full      = full_w;
    assign Empty     = empty_w;
    assign Overflow  = overflow_q;
    assign Collision = collision_q;
endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - randomized bench for alu_result_queue against a queue reference model
module tb_alu_result_queue;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] Arith_OUT;
    logic       Arith_Flag;
    logic [4:0] Logic_OUT;
    logic       Logic_Flag;
    logic [2:0] CMP_OUT;
    logic       CMP_Flag;
    logic [4:0] SHIFT_OUT;
    logic       SHIFT_Flag;
    logic       CLR;
    logic [2:0] Count;
    logic       Full;
    logic       Empty;
    logic       Overflow;
    logic       Collision;

    alu_result_queue_if #(.OUT_WIDTH(10)) rif ();

    alu_result_queue #(
        .ARITH_WIDTH(10), .LOGIC_WIDTH(5), .CMP_WIDTH(3),
        .SHIFT_WIDTH(5), .OUT_WIDTH(10), .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .SHIFT_OUT(SHIFT_OUT), .SHIFT_Flag(SHIFT_Flag),
        .CLR(CLR), .res(rif),
        .Count(Count), .Full(Full), .Empty(Empty),
        .Overflow(Overflow), .Collision(Collision)
    );

    always #5 CLK = ~CLK;

    // Reference: a plain queue of {src, data}, plus sticky bits
    logic [11:0] mq[$];
    bit          m_ovf;
    bit          m_coll;
    int          wr_idx;
    int          wraps;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, 32'(Count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(Empty), 32'(mq.size() == 0));
        check({tag, "_full"}, 32'(Full), 32'(mq.size() == DEPTH));
        check({tag, "_valid"}, 32'(rif.Res_Valid), 32'(mq.size() != 0));
        check({tag, "_ovf"}, 32'(Overflow), 32'(m_ovf));
        check({tag, "_coll"}, 32'(Collision), 32'(m_coll));
        if (mq.size() != 0) begin
            check({tag, "_data"}, 32'(rif.Res_Data), 32'(mq[0][9:0]));
            check({tag, "_src"}, 32'(rif.Res_Src), 32'(mq[0][11:10]));
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 0;
        m_coll = 0;
        wr_idx = 0;
    endtask

    task automatic idle_inputs();
        Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; SHIFT_Flag = 0; CLR = 0;
    endtask

    // Capture inputs before the edge, advance one clock, update the model, compare
    task automatic cycle(input string tag);
        int          nflags;
        bit          pop;
        bit          clr;
        bit          have;
        logic [11:0] ent;
        nflags = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(SHIFT_Flag);
        pop    = (mq.size() > 0) && rif.Res_Ready;
        clr    = CLR;
        have   = 1;
        if (Arith_Flag)      ent = {2'b00, Arith_OUT};
        else if (Logic_Flag) ent = {2'b01, 5'b0, Logic_OUT};
        else if (CMP_Flag)   ent = {2'b10, 7'b0, CMP_OUT};
        else if (SHIFT_Flag) ent = {2'b11, 5'b0, SHIFT_OUT};
        else begin
            ent  = '0;
            have = 0;
        end
        @(posedge CLK);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            if (nflags > 1) m_coll = 1;
            if (have && mq.size() == DEPTH && !pop) m_ovf = 1;
            if (pop) void'(mq.pop_front());
            if (have && mq.size() < DEPTH) begin
                mq.push_back(ent);
                wr_idx++;
                if (wr_idx % DEPTH == 0) wraps++;
            end
        end
        check_all(tag);
    endtask

    logic [1:0] exp_src [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [9:0] exp_dat [4] = '{10'h3FF, 10'h001, 10'h01F, 10'h00A};

    task automatic fill4();
        Arith_Flag = 1; Arith_OUT = 10'h3FF; cycle("fill_a");
        Arith_Flag = 0; CMP_Flag = 1; CMP_OUT = 3'b001; cycle("fill_c");
        CMP_Flag = 0; SHIFT_Flag = 1; SHIFT_OUT = 5'h1F; cycle("fill_s");
        SHIFT_Flag = 0; Logic_Flag = 1; Logic_OUT = 5'h0A; cycle("fill_l");
        Logic_Flag = 0;
    endtask

    initial begin
        wraps = 0;
        RST = 0;
        idle_inputs();
        Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; SHIFT_OUT = '0;
        rif.Res_Ready = 0;
        model_reset();
        @(posedge CLK);
        #1;
        check_all("reset");
        check("reset_data", 32'(rif.Res_Data), 32'h0);
        check("reset_src", 32'(rif.Res_Src), 32'h0);
        @(negedge CLK);
        RST = 1;

        Logic_Flag = 1; Logic_OUT = 5'b10110;
        cycle("t1_push");
        Logic_Flag = 0;
        check("t1_data", 32'(rif.Res_Data), 32'h016);
        check("t1_src", 32'(rif.Res_Src), 32'h1);
        check("t1_count", 32'(Count), 32'd1);
        rif.Res_Ready = 1;
        cycle("t1_pop");
        rif.Res_Ready = 0;
        check("t1_empty", 32'(Empty), 32'd1);

        fill4();
        check("t2_full", 32'(Full), 32'd1);
        check("t2_count", 32'(Count), 32'd4);
        rif.Res_Ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("t2_src", 32'(rif.Res_Src), 32'(exp_src[i]));
            check("t2_data", 32'(rif.Res_Data), 32'(exp_dat[i]));
            cycle("t2_drain");
        end
        rif.Res_Ready = 0;

        fill4();
        Arith_Flag = 1; Arith_OUT = 10'h155;
        cycle("t3_drop");
        check("t3_ovf", 32'(Overflow), 32'd1);
        check("t3_count", 32'(Count), 32'd4);
        check("t3_head", 32'(rif.Res_Data), 32'h3FF);
        rif.Res_Ready = 1; Arith_OUT = 10'h2AA;
        cycle("t3_pushpop");
        rif.Res_Ready = 0; Arith_Flag = 0;
        check("t3_count2", 32'(Count), 32'd4);
        CLR = 1; cycle("t3_clr"); CLR = 0;

        Arith_Flag = 1; Logic_Flag = 1; Arith_OUT = 10'h123; Logic_OUT = 5'h07;
        cycle("t4_coll");
        idle_inputs();
        check("t4_count", 32'(Count), 32'd1);
        check("t4_data", 32'(rif.Res_Data), 32'h123);
        check("t4_coll", 32'(Collision), 32'd1);
        CLR = 1; cycle("t4_clr"); CLR = 0;
        check("t4_coll_clr", 32'(Collision), 32'd0);

        for (int i = 0; i < 3; i++) begin
            SHIFT_Flag = 1; SHIFT_OUT = 5'(i + 3);
            cycle("t5_fill");
        end
        SHIFT_Flag = 0;
        #3;
        RST = 0;
        #1;
        model_reset();
        check("t5_empty", 32'(Empty), 32'd1);
        check("t5_valid", 32'(rif.Res_Valid), 32'd0);
        check("t5_count", 32'(Count), 32'd0);
        @(negedge CLK);
        RST = 1;
        CMP_Flag = 1; CMP_OUT = 3'b101;
        cycle("t5_push");
        CMP_Flag = 0;
        check("t5_count1", 32'(Count), 32'd1);
        check("t5_data", 32'(rif.Res_Data), 32'h005);

        wraps = 0;
        for (int n = 0; n < 1000; n++) begin
            Arith_Flag = ($urandom_range(0, 99) < 20);
            Logic_Flag = ($urandom_range(0, 99) < 20);
            CMP_Flag   = ($urandom_range(0, 99) < 20);
            SHIFT_Flag = ($urandom_range(0, 99) < 20);
            Arith_OUT  = 10'($urandom);
            Logic_OUT  = 5'($urandom);
            CMP_OUT    = 3'($urandom);
            SHIFT_OUT  = 5'($urandom);
            rif.Res_Ready = ($urandom_range(0, 99) < 55);
            CLR = ($urandom_range(0, 99) < 2);
            cycle("rnd");
        end
        idle_inputs();
        check("wrap_cov", 32'(wraps >= 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
